// File: rtl/i2s_tx.sv
// I2S stereo transmitter: generates bclk/lrclk from sysclk, serialises {L,R} MSB first.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified data (no one-slot delay).
module i2s_tx #(
    parameter int W        = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic         sysclk,
    input  logic         rst_n,
    input  logic [W-1:0] sample_l,
    input  logic [W-1:0] sample_r,
    input  logic         sample_valid,
    output logic         sample_ready,
    output logic         i2s_bclk,
    output logic         i2s_lrclk,
    output logic         i2s_sdata,
    output logic         underrun
);

    localparam int FW = 2 * W;
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(FW);
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] LAST    = BW'(FW - 1);
    localparam logic [BW-1:0] HALF    = BW'(W);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            bclk_q, bclk_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic [FW-1:0]   hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic            underrun_q, underrun_d;
    logic            accept;
    logic            tick;
    logic            fall;

    assign accept = sample_valid && !hold_full_q;
    assign tick   = (div_cnt_q == DIV_MAX);
    assign fall   = (state_q == S_RUN) && tick && bclk_q;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        underrun_d  = 1'b0;

        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            if (accept) begin
                state_d = S_RUN;
            end
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
            if (tick) begin
                bclk_d = ~bclk_q;
            end
            if (fall) begin
                bit_cnt_d = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + BW'(1);
                lrclk_d   = (bit_cnt_d >= HALF);
                if (bit_cnt_q == LAST) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d    = '0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    shift_d = {shift_q[FW-2:0], 1'b0};
                end
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
                sdata_d = shift_d[FW-1];
`else
                // Old MSB gives the one-slot I2S delay: slot 0 sends previous right LSB.
                sdata_d = shift_q[FW-1];
`endif
            end
        end

        // Load above only fires with holding full, so a same-cycle accept never bypasses.
        if (accept) begin
            hold_d      = {sample_l, sample_r};
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= LAST;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises stereo 16-bit PCM frames from the DSP core's sample output onto an I2S bus for an external DAC.
- It is the transmit end of the audio link and pairs with the capture path that feeds the DSP core.
- Generates its own bit clock and word select from sysclk.
- Accepts one {left, right} frame per word period through a valid/ready handshake into a single-entry holding register.

Parameters:
- W, 16: sample width per channel, in bits.
- BCLK_DIV, 4: sysclk cycles per half period of i2s_bclk; must be ≥ 2.

Ports:
- sysclk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_l  input  W  left sample, signed two's complement.
- sample_r  input  W  right sample, signed two's complement.
- sample_valid  input  1  frame on sample_l/sample_r is offered.
- sample_ready  output  1  holding register is empty; a frame is accepted when sample_valid && sample_ready.
- i2s_bclk  output  1  bit clock, period 2*BCLK_DIV sysclk cycles.
- i2s_lrclk  output  1  word select: 0 = left, 1 = right.
- i2s_sdata  output  1  serial data, MSB first; changes only on i2s_bclk falling edges.
- underrun  output  1  one-sysclk pulse when a frame starts with the holding register empty.

Behaviour:
- Reset values (async, rst_n=0):
  - state=S_IDLE; div_cnt=0; bit_cnt=2W-1.
  - i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0.
  - sample_ready=1, underrun=0; holding and shifter registers = 0.
- Reset asserted mid-frame aborts the frame immediately; all outputs return to reset values.
- S_IDLE:
  - div_cnt is held at 0; bclk and lrclk are held low.
  - On handshake: capture {sample_l, sample_r} into holding, drive sample_ready=0, and move to S_RUN on the next cycle.
- S_RUN, clock generation:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - At div_cnt==BCLK_DIV-1, i2s_bclk toggles.
  - The first toggle after entering S_RUN is a rising edge.
- S_RUN, per falling bclk edge (toggle 1→0), all in the same sysclk cycle:
  - bit_cnt advances (2W-1 wraps to 0).
  - i2s_lrclk <= (new bit_cnt ≥ W).
  - i2s_sdata is updated.
- Frame load (falling edge entering bit_cnt=0):
  - If holding is full: shifter <= holding and holding is marked empty, so sample_ready=1 on the next cycle.
  - If holding is empty: shifter <= 0 and underrun pulses for 1 cycle.
  - If a handshake happens in that same cycle, the new frame goes into holding and is used for the next frame. It is never bypassed into the current frame.
- Shifter is 2W bits, {L,R}, and shifts left by one on every subsequent falling edge.
- I2S data alignment (default): sdata is the shifter MSB delayed by one bit slot.
  - Slot 0 carries the previous frame's right LSB.
  - Slot 1 carries the left MSB.
  - Slot W+1 carries the right MSB.
- No return to S_IDLE except by reset; on underrun the bus keeps running and sends zeros.
- No arithmetic on samples; bits pass through unchanged.
- Frame period = 2W*2*BCLK_DIV sysclk cycles (256 with defaults).
- Upstream must supply one frame per frame period to avoid underrun.

Optional Feature:
- I2S_TX_LEFT_JUSTIFIED_EN:
  - Defined: left-justified format. The one-slot delay stage is removed and sdata = shifter MSB directly, so slot 0 carries the left MSB and slot W carries the right MSB. lrclk timing is unchanged.
  - Undefined: standard I2S one-slot delay as described above.

Test Plan:
- Reset then idle, no valid for 100 cycles → bclk, lrclk and sdata stay 0; sample_ready=1; underrun never pulses.
- Single frame L=16'hA5F0, R=16'h0F0F → lrclk low for 16 bclk cycles then high for 16. On the 32 falling edges, sdata reads 0,A5F0 MSB-first,0F0F MSB-first minus its LSB; the right LSB appears in slot 0 of the next frame. sample_ready returns to 1 on the cycle after the first load.
- Continuous frames, valid held high, alternating 16'h8000/16'h7FFF → bclk period 8 cycles and frame period 256 cycles; underrun is never asserted; every frame is reproduced bit-exact.
- Starve after one frame → the second frame sends all zeros; underrun is high for exactly 1 cycle on the load edge of that frame; bclk and lrclk continue uninterrupted.
- Handshake in the same cycle as an empty-holding load, with L=16'h1234 → the current frame is zeros with an underrun pulse; the next frame carries 16'h1234.
- rst_n pulsed low mid right-word, at bit_cnt=20 → outputs go to 0 immediately; after release, sample_ready=1 and state is S_IDLE; the next accepted frame is transmitted from slot 0.
- With I2S_TX_LEFT_JUSTIFIED_EN defined, L=16'h8001 → sdata=1 in slot 0 and slot 15, and 0 in slots 1-14.
